maxnet_controller: RTL and testbench
====================================

Name: maxnet_controller

Overview:
Sequencing FSM for the Maxnet winner-take-all datapath. On start it loads the 4 neuron working registers from the data memory. It then repeats calculate/update iterations until exactly one neuron stays non-zero, all neurons reach zero, or an iteration cap is hit. It sits between the top-level start/done handshake and the datapath's load and enable strobes.

Parameters:
N, 4, number of neurons (one per data-memory word)
MAX_ITER, 16, iteration cap before timeout
CALC_CYCLES, 2, cycles calc_en is held per iteration (datapath multiply/accumulate latency), >=1
ITER_W, 5, width of iteration counter; must hold MAX_ITER
IDX_W, 2, width of winner index, clog2(N)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a run; sampled only in IDLE or DONE
nz_mask  in  N  per-neuron "value > 0" flags from datapath working registers
ld_init  out  1  load working registers from data memory (1-cycle pulse)
calc_en  out  1  datapath compute enable
ld_update  out  1  write computed values back to working registers (1-cycle pulse)
busy  out  1  high in every state except IDLE and DONE
done  out  1  run finished; held until next start or reset
winner_valid  out  1  exactly one neuron non-zero at finish
winner_idx  out  IDX_W  index of surviving neuron; 0 when winner_valid=0
iter_count  out  ITER_W  completed update iterations in current/last run
timeout  out  1  finished because iter_count reached MAX_ITER

Behaviour:
- Reset: async, active-high. State goes to IDLE. All outputs go to 0 and counters clear. Reset mid-run aborts immediately; no further strobes are issued.
- States: IDLE, INIT, CHECK, CALC, UPDATE, DONE.
- IDLE: start=1 -> INIT.
- INIT: ld_init=1 for one cycle. Clears iter_count, calc counter, done, timeout, winner_valid and winner_idx. Goes to CHECK.
- CHECK: evaluate nz_mask in one cycle, no strobes. Priority order:
  - popcount==1 -> DONE, winner_valid=1, winner_idx=index of the set bit.
  - popcount==0 -> DONE, winner_valid=0.
  - iter_count==MAX_ITER -> DONE, timeout=1, winner_valid=0.
  - otherwise -> CALC.
- CALC: calc_en=1 for exactly CALC_CYCLES cycles, using a down-counter loaded on CHECK->CALC. Then goes to UPDATE.
- UPDATE: ld_update=1 for one cycle. iter_count increments and saturates at MAX_ITER. Goes to CHECK.
- DONE: done=1, busy=0. Results are held. start=1 -> INIT; done drops on the INIT cycle.
- start outside IDLE/DONE is ignored.
- ld_init, calc_en and ld_update are Moore outputs decoded from the state register. No glitching; never more than one is high.
- done, winner_valid, winner_idx and timeout are registered and change only on entry to DONE or INIT.
- Timing: start sampled at edge 0 -> INIT in cycle 1 -> CHECK in cycle 2. Each iteration takes CALC_CYCLES+2 cycles, so done rises after 2 + k*(CALC_CYCLES+2) + 1 edges for k iterations.
- nz_mask is assumed stable from ld_update+1 through CHECK. The datapath registers it.

Decomposition:
- Package maxnet_pkg: state enum, N, IDX_W, default MAX_ITER and CALC_CYCLES constants.
- Sub-module maxnet_winner_detect: combinational nz_mask -> {is_zero, is_one, idx}. Popcount plus one-hot-to-index conversion, parameterised on N.

Test Plan:
1. nz_mask=4'b0100 from INIT onward -> done=1 with no calc_en ever asserted, winner_valid=1, winner_idx=2, iter_count=0, done high 3 edges after start.
2. nz_mask sequence 1111 -> 0111 -> 0011 -> 0010, each changing after ld_update (CALC_CYCLES=2) -> 3 ld_update pulses, calc_en high 2 cycles each, winner_idx=1, iter_count=3, done at edge 15.
3. MAX_ITER=4, nz_mask held 1100 -> exactly 4 ld_update pulses, timeout=1, winner_valid=0, winner_idx=0, iter_count=4.
4. nz_mask goes 0011 -> 0000 after first update -> done=1, winner_valid=0, timeout=0, iter_count=1.
5. rst pulsed mid-CALC -> all outputs 0 asynchronously, no ld_update follows. After release, a new start runs scenario 1 cleanly.
6. Extra start pulses while busy are ignored (run completes unchanged). start in DONE clears done on the next edge and issues a new ld_init.

Source files
------------

// File: rtl/maxnet_pkg.sv
`default_nettype none
// ============================================================================
// maxnet_pkg : shared types and constants for the Maxnet sequencing controller
// Revision   : 1.0
// ============================================================================
package maxnet_pkg;

    localparam int N               = 4;
    localparam int IDX_W           = 2;
    localparam int DEF_MAX_ITER    = 16;
    localparam int DEF_CALC_CYCLES = 2;
    localparam int DEF_ITER_W      = 5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_CHECK  = 3'd2,
        S_CALC   = 3'd3,
        S_UPDATE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/maxnet_if.sv
`default_nettype none
// ============================================================================
// maxnet_if : start/done handshake and datapath strobes of the Maxnet controller
// Revision  : 1.0
// ============================================================================
interface maxnet_if #(
    parameter int N      = 4,
    parameter int IDX_W  = 2,
    parameter int ITER_W = 5
);
    logic              start;
    logic [N-1:0]      nz_mask;
    logic              ld_init;
    logic              calc_en;
    logic              ld_update;
    logic              busy;
    logic              done;
    logic              winner_valid;
    logic [IDX_W-1:0]  winner_idx;
    logic [ITER_W-1:0] iter_count;
    logic              timeout;

    modport master (
        output start, nz_mask,
        input  ld_init, calc_en, ld_update, busy, done,
        input  winner_valid, winner_idx, iter_count, timeout
    );

    modport slave (
        input  start, nz_mask,
        output ld_init, calc_en, ld_update, busy, done,
        output winner_valid, winner_idx, iter_count, timeout
    );
endinterface
`default_nettype wire

// File: rtl/maxnet_winner_detect.sv
`default_nettype none
// ============================================================================
// maxnet_winner_detect : popcount and one-hot-to-index of the non-zero mask
// Revision             : 1.0
// ============================================================================
module maxnet_winner_detect #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  wire logic [N-1:0]     nz_mask_i,
    output logic                  is_zero_o,
    output logic                  is_one_o,
    output logic [IDX_W-1:0]      idx_o
);

    localparam int CNT_W = $clog2(N + 1);

    logic [CNT_W-1:0] w_count;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
        w_count = '0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            w_count = w_count + CNT_W'(nz_mask_i[i]);
            if (nz_mask_i[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    assign is_zero_o = (w_count == '0);
    assign is_one_o  = (w_count == CNT_W'(1));
    // Index is only meaningful for a single survivor; force 0 otherwise.
    assign idx_o     = is_one_o ? w_idx : '0;

endmodule
`default_nettype wire

// File: rtl/maxnet_controller.sv
`default_nettype none
// ============================================================================
// maxnet_controller : load / calculate / update sequencer for winner-take-all
// Revision          : 1.0
// ============================================================================
module maxnet_controller
    import maxnet_pkg::*;
#(
    parameter int MAX_ITER    = DEF_MAX_ITER,
    parameter int CALC_CYCLES = DEF_CALC_CYCLES,
    parameter int ITER_W      = DEF_ITER_W
) (
    input  wire logic clk,
    input  wire logic rst,
    maxnet_if.slave   bus
);

    localparam int                CALC_W    = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;
    localparam logic [CALC_W-1:0] CALC_LOAD = CALC_W'(CALC_CYCLES - 1);
    localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(MAX_ITER);

    state_t             state_q, state_d;
    logic [CALC_W-1:0]  calc_cnt_q;
    logic [ITER_W-1:0]  iter_q;
    logic               ld_init_q, calc_en_q, ld_update_q, busy_q;
    logic               done_q, winner_valid_q, timeout_q;
    logic [IDX_W-1:0]   winner_idx_q;

    logic               w_is_zero, w_is_one;
    logic [IDX_W-1:0]   w_idx;

    maxnet_winner_detect #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_detect (
        .nz_mask_i (bus.nz_mask),
        .is_zero_o (w_is_zero),
        .is_one_o  (w_is_one),
        .idx_o     (w_idx)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_INIT;
            S_INIT:   state_d = S_CHECK;
            S_CHECK: begin
                if (w_is_one || w_is_zero || (iter_q == ITER_MAX)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_CALC:   if (calc_cnt_q == '0) state_d = S_UPDATE;
            S_UPDATE: state_d = S_CHECK;
            S_DONE:   if (bus.start) state_d = S_INIT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobes are registered decodes of the next state, so they track the
    // state register exactly and cannot glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            calc_cnt_q     <= '0;
            iter_q         <= '0;
            ld_init_q      <= 1'b0;
            calc_en_q      <= 1'b0;
            ld_update_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            winner_valid_q <= 1'b0;
            winner_idx_q   <= '0;
            timeout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_init_q   <= (state_d == S_INIT);
            calc_en_q   <= (state_d == S_CALC);
            ld_update_q <= (state_d == S_UPDATE);
            busy_q      <= (state_d != S_IDLE) && (state_d != S_DONE);

            case (state_q)
                S_CHECK: begin
                    if (state_d == S_CALC) begin
                        calc_cnt_q <= CALC_LOAD;
                    end else begin
                        done_q         <= 1'b1;
                        winner_valid_q <= w_is_one;
                        winner_idx_q   <= w_idx;
                        timeout_q      <= !w_is_one && !w_is_zero;
                    end
                end
                S_CALC: begin
                    if (calc_cnt_q != '0) calc_cnt_q <= calc_cnt_q - 1'b1;
                end
                S_UPDATE: begin
                    if (iter_q != ITER_MAX) iter_q <= iter_q + 1'b1;
                end
                default: ;
            endcase

            if (state_d == S_INIT) begin
                calc_cnt_q     <= '0;
                iter_q         <= '0;
                done_q         <= 1'b0;
                winner_valid_q <= 1'b0;
                winner_idx_q   <= '0;
                timeout_q      <= 1'b0;
            end
        end
    end

    assign bus.ld_init      = ld_init_q;
    assign bus.calc_en      = calc_en_q;
    assign bus.ld_update    = ld_update_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.winner_valid = winner_valid_q;
    assign bus.winner_idx   = winner_idx_q;
    assign bus.iter_count   = iter_q;
    assign bus.timeout      = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_maxnet_controller.sv
`default_nettype none
// ============================================================================
// tb_maxnet_controller : directed and random runs against a run-level model
// Revision             : 1.0
// ============================================================================
module tb_maxnet_controller;

    localparam int MAX_ITER    = 4;
    localparam int CALC_CYCLES = 2;
    localparam int ITER_W      = 5;
    localparam int BUDGET      = 200;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    maxnet_if #(.N(4), .IDX_W(2), .ITER_W(ITER_W)) bus ();

    maxnet_controller #(
        .MAX_ITER    (MAX_ITER),
        .CALC_CYCLES (CALC_CYCLES),
        .ITER_W      (ITER_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] all_outs();
        return {bus.ld_init, bus.calc_en, bus.ld_update, bus.busy, bus.done,
                bus.winner_valid, bus.winner_idx, bus.iter_count, bus.timeout};
    endfunction

    // One full run: the model derives the outcome from the mask sequence the
    // datapath would present at each successive CHECK.
    task automatic run_scenario(input string name, input logic [3:0] seq[$], input bit noisy);
        int exp_k, exp_edges, edges, pos, n_init, n_calc, n_upd, n_excl, n_busy;
        bit exp_wv, exp_to;
        logic [1:0] exp_idx;
        logic [3:0] m;
        exp_k = 0; exp_wv = 0; exp_to = 0; exp_idx = 0;
        while (1) begin
            m = seq[(exp_k < seq.size()) ? exp_k : seq.size() - 1];
            if ($countones(m) == 1) begin exp_wv = 1; exp_idx = 2'($clog2(m)); break; end
            if (m == 4'd0) break;
            if (exp_k == MAX_ITER) begin exp_to = 1; break; end
            exp_k++;
        end
        exp_edges = 3 + exp_k * (CALC_CYCLES + 2);

        n_init = 0; n_calc = 0; n_upd = 0; n_excl = 0; n_busy = 0; pos = 0;
        bus.nz_mask = seq[0];
        bus.start   = 1'b1;
        @(posedge clk); edges = 1;
        @(negedge clk); bus.start = 1'b0;
        while (!bus.done && edges < BUDGET) begin
            n_init += int'(bus.ld_init);
            n_calc += int'(bus.calc_en);
            n_upd  += int'(bus.ld_update);
            if (int'(bus.ld_init) + int'(bus.calc_en) + int'(bus.ld_update) > 1) n_excl++;
            if (!bus.busy) n_busy++;
            if (bus.ld_update && pos < seq.size() - 1) begin pos++; bus.nz_mask = seq[pos]; end
            bus.start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); edges++;
            @(negedge clk); bus.start = 1'b0;
        end

        n_cmp++; if (edges !== exp_edges) begin n_fail++; $display("FAIL %s done_edge: got %0d want %0d", name, edges, exp_edges); end
        n_cmp++; if (n_init !== 1) begin n_fail++; $display("FAIL %s ld_init_pulses: got %0d want 1", name, n_init); end
        n_cmp++; if (n_calc !== exp_k * CALC_CYCLES) begin n_fail++; $display("FAIL %s calc_cycles: got %0d want %0d", name, n_calc, exp_k * CALC_CYCLES); end
        n_cmp++; if (n_upd !== exp_k) begin n_fail++; $display("FAIL %s ld_update_pulses: got %0d want %0d", name, n_upd, exp_k); end
        n_cmp++; if (n_excl !== 0) begin n_fail++; $display("FAIL %s strobe_overlap: got %0d want 0", name, n_excl); end
        n_cmp++; if (n_busy !== 0) begin n_fail++; $display("FAIL %s busy_low_in_run: got %0d want 0", name, n_busy); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_at_done: got %b want 0", name, bus.busy); end
        n_cmp++; if (bus.winner_valid !== exp_wv) begin n_fail++; $display("FAIL %s winner_valid: got %b want %b", name, bus.winner_valid, exp_wv); end
        n_cmp++; if (bus.winner_idx !== exp_idx) begin n_fail++; $display("FAIL %s winner_idx: got %0d want %0d", name, bus.winner_idx, exp_idx); end
        n_cmp++; if (bus.iter_count !== ITER_W'(exp_k)) begin n_fail++; $display("FAIL %s iter_count: got %0d want %0d", name, bus.iter_count, exp_k); end
        n_cmp++; if (bus.timeout !== exp_to) begin n_fail++; $display("FAIL %s timeout: got %b want %b", name, bus.timeout, exp_to); end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.nz_mask = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (all_outs() !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", all_outs()); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (all_outs() !== '0) begin n_fail++; $display("FAIL idle_outputs: got %h want 0", all_outs()); end
    endtask

    task automatic test_directed();
        run_scenario("single_winner", '{4'b0100}, 1'b0);
        run_scenario("converge",      '{4'b1111, 4'b0111, 4'b0011, 4'b0010}, 1'b0);
        run_scenario("timeout",       '{4'b1100}, 1'b0);
        run_scenario("all_zero",      '{4'b0011, 4'b0000}, 1'b0);
    endtask

    task automatic test_reset_mid_calc();
        int cyc, n_upd;
        bus.nz_mask = 4'b1111;
        bus.start   = 1'b1;
        @(posedge clk);
        @(negedge clk); bus.start = 1'b0;
        cyc = 0;
        while (!bus.calc_en && cyc < 20) begin @(negedge clk); cyc++; end
        n_cmp++; if (bus.calc_en !== 1'b1) begin n_fail++; $display("FAIL reach_calc: got %b want 1", bus.calc_en); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (all_outs() !== '0) begin n_fail++; $display("FAIL async_reset_outputs: got %h want 0", all_outs()); end
        n_upd = 0;
        repeat (2) begin @(negedge clk); n_upd += int'(bus.ld_update); end
        rst = 1'b0;
        repeat (4) begin @(negedge clk); n_upd += int'(bus.ld_update); end
        n_cmp++; if (n_upd !== 0) begin n_fail++; $display("FAIL post_reset_ld_update: got %0d want 0", n_upd); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", bus.busy); end
        run_scenario("after_reset", '{4'b0100}, 1'b0);
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_scenario("noisy_start", '{4'b1111, 4'b1011, 4'b1000}, 1'b1);
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.done !== 1'b1 || bus.winner_idx !== 2'd3) begin n_fail++; $display("FAIL done_hold: got done=%b idx=%0d want done=1 idx=3", bus.done, bus.winner_idx); end
        bus.nz_mask = 4'b0001;
        bus.start   = 1'b1;
        @(posedge clk);
        @(negedge clk); bus.start = 1'b0;
        n_cmp++; if (bus.done !== 1'b0 || bus.ld_init !== 1'b1) begin n_fail++; $display("FAIL restart: got done=%b ld_init=%b want done=0 ld_init=1", bus.done, bus.ld_init); end
        cyc = 0;
        while (!bus.done && cyc < BUDGET) begin @(negedge clk); cyc++; end
        n_cmp++; if (bus.done !== 1'b1 || bus.winner_idx !== 2'd0 || bus.winner_valid !== 1'b1) begin n_fail++; $display("FAIL restart_result: got done=%b wv=%b idx=%0d want 1 1 0", bus.done, bus.winner_valid, bus.winner_idx); end
    endtask

    task automatic test_random();
        logic [3:0] seq[$];
        int len;
        for (int r = 0; r < 24; r++) begin
            seq.delete();
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) seq.push_back(4'($urandom_range(0, 15)));
            run_scenario($sformatf("random%0d", r), seq, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        test_reset();
        test_directed();
        test_reset_mid_calc();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
